logic_cmd_unit: RTL and testbench
=================================

# logic_cmd_unit

Byte-stream command front end for the calculator's bitwise logic operations. Receives framed commands (opcode plus two 32-bit operands) from the Python middleware link, executes the selected logic operation, and returns a framed response byte stream. Sits between the middleware byte interface and the logic operation datapath; it is the command/response end of the path the logic operators serve.

## Interface
- `DATA_W`, 32: operand/result width in bits; must be a multiple of 8. `NB = DATA_W/8` bytes per operand.
- `TIMEOUT_CYCLES`, 1024: maximum idle cycles between bytes of one command frame before the frame is dropped; 0 disables the timeout.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command byte valid.
- `in_data`  in  8  command byte.
- `in_ready`  out  1  unit accepts a command byte this cycle.
- `out_valid`  out  1  response byte valid.
- `out_data`  out  8  response byte.
- `out_ready`  in  1  downstream accepts a response byte.
- `busy`  out  1  a frame is in progress; high in any state other than IDLE.
- `err`  out  1  one-cycle pulse on a bad opcode or a frame timeout.

## Operation
- Command frame: 1 opcode byte, then NB bytes of P, then NB bytes of Q, each operand MSB-first. A byte transfers when `in_valid && in_ready`.
- Opcodes: 0x00 AND, 0x01 NAND, 0x02 NOR, 0x03 NOT, 0x04 OR, 0x05 XNOR, 0x06 XOR. All other values are bad opcodes.
- Results: AND P&Q; NAND ~(P&Q); NOR ~(P|Q); NOT ~Q (P is ignored); OR P|Q; XNOR ~(P^Q); XOR P^Q. All results are full DATA_W wide.
- Response frame: 1 status byte (0x00 OK, 0xEE bad opcode), then NB result bytes, MSB-first. A bad opcode returns a result of 0.
- A bad opcode still consumes the full 2*NB operand bytes, so frame alignment with the middleware is preserved. `err` pulses in the EXEC cycle.
- FSM states and transitions:
  - IDLE: opcode byte → GET_P.
  - GET_P: after NB bytes → GET_Q.
  - GET_Q: after NB bytes → EXEC.
  - EXEC: one cycle; result and status are registered → SEND.
  - SEND: after NB+1 bytes accepted → IDLE.
- Byte counter: counts 0..NB-1 in GET_P/GET_Q and 0..NB in SEND, and clears on every state change.
- Timeout: an idle counter runs in GET_P/GET_Q. It clears on each accepted byte. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, the partial frame is discarded, `err` pulses, and no response is sent. The timeout is never applied in SEND, where backpressure may last indefinitely.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0x00, `busy`=0, `err`=0; FSM in IDLE; counters at 0. `in_ready` rises in the first cycle after reset deasserts.
- `in_ready`=1 in IDLE, GET_P and GET_Q; 0 in EXEC and SEND. The unit accepts no new command while a response is pending.
- Latency: last Q byte accepted in cycle N → EXEC in cycle N+1 → `out_valid`=1 with the status byte in cycle N+2.
- Output hold: `out_valid`/`out_data` stay stable while `out_ready`=0. The next byte appears in the cycle after a transfer. With `out_ready` held high, one byte transfers per cycle.
- Last response byte accepted in cycle M → IDLE with `in_ready`=1 in cycle M+1.
- Asserting `rst_n` low at any point aborts immediately: all outputs return to their reset values and any partial command or response is lost.

## Structure
- Package `logic_cmd_pkg` holds:
  - opcode constants (0x00–0x06);
  - status constants STAT_OK=0x00 and STAT_BADOP=0xEE;
  - the FSM state enum (IDLE, GET_P, GET_Q, EXEC, SEND).
- Sub-module `logic_op_bank`: combinational; takes P, Q and opcode, and outputs the result plus a `bad_op` flag. `logic_cmd_unit` registers its outputs in EXEC.
- P/Q assembly and result serialization use shift registers in the top module.

## Test plan
- AND: frame 00 12 34 56 78 0F 0F 0F 0F with `out_ready`=1 → response 00 02 04 06 08; `out_valid` first high 2 cycles after the last input byte.
- XOR and NOT:
  - 06 FF FF 00 00 0F 0F 0F 0F → response 00 F0 F0 0F 0F;
  - 03 AA AA AA AA 00 FF 00 FF → response 00 FF 00 FF 00.
- Bad opcode: 09 followed by 8 arbitrary bytes → `err` pulses for one cycle and the response is EE 00 00 00 00. A following AND frame then decodes correctly.
- Backpressure: `out_ready` toggles randomly during an OR frame 04 F0 00 00 01 0F 00 00 10 → bytes 00 FF 00 00 11 arrive in order, unchanged while stalled; `in_ready`=0 until the last byte is taken.
- Timeout (TIMEOUT_CYCLES=16): send 00 11 22, then idle 16 cycles → `err` pulses, `busy` falls, no response. The next full frame is handled normally.
- Reset mid-SEND: drop `rst_n` after 2 response bytes → outputs go to reset values at once and no further response bytes appear; a new frame after reset completes correctly.

Source files
------------

// File: rtl/logic_cmd_pkg.sv
// Shared constants and FSM encoding for the logic command front end.
package logic_cmd_pkg;
  localparam logic [7:0] OP_AND  = 8'h00;
  localparam logic [7:0] OP_NAND = 8'h01;
  localparam logic [7:0] OP_NOR  = 8'h02;
  localparam logic [7:0] OP_NOT  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_XNOR = 8'h05;
  localparam logic [7:0] OP_XOR  = 8'h06;

  localparam logic [7:0] STAT_OK    = 8'h00;
  localparam logic [7:0] STAT_BADOP = 8'hEE;

  typedef enum logic [2:0] {IDLE, GET_P, GET_Q, EXEC, SEND} state_t;
endpackage

// File: rtl/logic_cmd_unit_if.sv
// Command/response byte streams between the middleware link and the unit.
interface logic_cmd_unit_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/logic_op_bank.sv
// Combinational bitwise operator bank; unknown opcodes yield zero and bad_op.
module logic_op_bank
    import logic_cmd_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] p,
    input  logic [DATA_W-1:0] q,
    input  logic [7:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              bad_op
);
    always_comb begin
        result = '0;
        bad_op = 1'b0;
        case (opcode)
            OP_AND:  result = p & q;
            OP_NAND: result = ~(p & q);
            OP_NOR:  result = ~(p | q);
            OP_NOT:  result = ~q;
            OP_OR:   result = p | q;
            OP_XNOR: result = ~(p ^ q);
            OP_XOR:  result = p ^ q;
            default: bad_op = 1'b1;
        endcase
    end
endmodule

// File: rtl/logic_cmd_unit.sv
// Framed command receiver: opcode + P + Q bytes in, status + result bytes out.
module logic_cmd_unit
    import logic_cmd_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_cmd_unit_if.slave  bus,
    output logic             busy,
    output logic             err
);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(NB + 1) + 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
    localparam int OUT_W = (NB + 1) * 8;

    state_t              state, nextState;
    logic [CNT_W-1:0]    byteCnt;
    logic [TO_W-1:0]     idleCnt;
    logic                armed;
    logic [7:0]          opcode;
    logic [DATA_W-1:0]   pShift, qShift, bankResult;
    logic [OUT_W-1:0]    outShift;
    logic                bankBad, inGet, inFire, outFire, cntLast, timeoutHit;

    logic_op_bank #(.DATA_W(DATA_W)) opBank (
        .p(pShift), .q(qShift), .opcode(opcode), .result(bankResult), .bad_op(bankBad)
    );

    assign inGet   = (state == GET_P) || (state == GET_Q);
    assign inFire  = bus.in_valid && bus.in_ready;
    assign outFire = bus.out_valid && bus.out_ready;
    assign cntLast = (state == SEND) ? (byteCnt == CNT_W'(NB)) : (byteCnt == CNT_W'(NB - 1));
    // Fires on the last idle cycle so it can never collide with an accepted byte.
    assign timeoutHit = (TIMEOUT_CYCLES != 0) && inGet && !inFire &&
                        (idleCnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (inFire) nextState = GET_P;
            GET_P:   if (timeoutHit) nextState = IDLE;
                     else if (inFire && cntLast) nextState = GET_Q;
            GET_Q:   if (timeoutHit) nextState = IDLE;
                     else if (inFire && cntLast) nextState = EXEC;
            EXEC:    nextState = SEND;
            SEND:    if (outFire && cntLast) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = armed && (state == IDLE || inGet);
        bus.out_valid = (state == SEND);
        bus.out_data  = outShift[OUT_W-1 -: 8];
        busy          = (state != IDLE);
        err           = ((state == EXEC) && bankBad) || timeoutHit;
    end

    // Shifting zeros in means out_data drains back to 0x00 after the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            byteCnt  <= '0;
            idleCnt  <= '0;
            opcode   <= '0;
            pShift   <= '0;
            qShift   <= '0;
            outShift <= '0;
        end else begin
            armed <= 1'b1;
            if (state != nextState)
                byteCnt <= '0;
            else if ((inGet && inFire) || ((state == SEND) && outFire))
                byteCnt <= byteCnt + 1'b1;
            if (!inGet || inFire || (state != nextState)) idleCnt <= '0;
            else                                          idleCnt <= idleCnt + 1'b1;
            if ((state == IDLE) && inFire)  opcode <= bus.in_data;
            if ((state == GET_P) && inFire) pShift <= (pShift << 8) | DATA_W'(bus.in_data);
            if ((state == GET_Q) && inFire) qShift <= (qShift << 8) | DATA_W'(bus.in_data);
            if (state == EXEC)              outShift <= {(bankBad ? STAT_BADOP : STAT_OK), bankResult};
            else if ((state == SEND) && outFire) outShift <= outShift << 8;
        end
    end
endmodule

// File: tb/tb_logic_cmd_unit.sv
// Table vectors, random frames vs. a reference model, and timeout/reset/backpressure sequences.
module tb_logic_cmd_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, err;
    int   checks = 0;
    int   failures = 0;

    logic_cmd_unit_if bus();

    logic_cmd_unit #(.DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] frame;
        logic [39:0] resp;
        logic        badop;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] model(input logic [7:0] op, input logic [31:0] p, input logic [31:0] q);
        case (op)
            8'h00:   return {8'h00, p & q};
            8'h01:   return {8'h00, ~(p & q)};
            8'h02:   return {8'h00, ~(p | q)};
            8'h03:   return {8'h00, ~q};
            8'h04:   return {8'h00, p | q};
            8'h05:   return {8'h00, ~(p ^ q)};
            8'h06:   return {8'h00, p ^ q};
            default: return {8'hEE, 32'h0};
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("in_ready_wait", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [71:0] f);
        for (int i = 0; i < 9; i++) sendByte(f[71 - 8*i -: 8]);
    endtask

    task automatic recvResp(input int n, input bit bp, output logic [39:0] got);
        int k = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] prev = 8'h00;
        got = '0;
        while (k < n && cyc < 300) begin
            if (stalled) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev);
            end
            if (bus.out_valid) check("in_ready_in_send", bus.in_ready, 0);
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                got = {got[31:0], bus.out_data};
                k++;
                stalled = 1'b0;
            end else begin
                stalled = bus.out_valid;
                prev    = bus.out_data;
            end
            @(negedge clk);
            cyc++;
        end
        if (k < n) check("recv_budget", k, n);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] got;
        logic [7:0]  op;
        logic [31:0] p, q;
        int errCnt, errAt;
        bit sawValid;

        vecs[0]  = '{72'h00_12345678_0F0F0F0F, 40'h00_02040608, 1'b0};
        vecs[1]  = '{72'h06_FFFF0000_0F0F0F0F, 40'h00_F0F00F0F, 1'b0};
        vecs[2]  = '{72'h03_AAAAAAAA_00FF00FF, 40'h00_FF00FF00, 1'b0};
        vecs[3]  = '{72'h01_FF00FF00_0F0F0F0F, 40'h00_F0FFF0FF, 1'b0};
        vecs[4]  = '{72'h02_F0F00000_0F000F00, 40'h00_000FF0FF, 1'b0};
        vecs[5]  = '{72'h05_12345678_123400FF, 40'h00_FFFFA978, 1'b0};
        vecs[6]  = '{72'h09_DEADBEEF_01234567, 40'hEE_00000000, 1'b1};
        vecs[7]  = '{72'h00_FFFFFFFF_80000001, 40'h00_80000001, 1'b0};
        vecs[8]  = '{72'h04_00FF00FF_0F0F0000, 40'h00_0FFF00FF, 1'b0};
        vecs[9]  = '{72'hFF_11111111_22222222, 40'hEE_00000000, 1'b1};
        vecs[10] = '{72'h07_00000000_FFFFFFFF, 40'hEE_00000000, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", bus.in_ready, 1);

        for (int v = 0; v < 11; v++) begin
            sendFrame(vecs[v].frame);
            check("exec_valid_low", bus.out_valid, 0);
            check("exec_err", err, vecs[v].badop);
            check("exec_busy", busy, 1);
            @(negedge clk);
            check("first_valid", bus.out_valid, 1);
            check("err_one_cycle", err, 0);
            recvResp(5, 1'b0, got);
            check($sformatf("vec%0d_resp", v), got, vecs[v].resp);
            check("idle_ready", bus.in_ready, 1);
            check("idle_busy", busy, 0);
        end

        // Backpressure on an OR frame.
        sendFrame(72'h04_F0000001_0F000010);
        recvResp(5, 1'b1, got);
        check("bp_or_resp", got, 40'h00_FF000011);
        check("bp_idle_ready", bus.in_ready, 1);

        // Random frames against the model.
        for (int r = 0; r < 40; r++) begin
            op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            p  = $urandom;
            q  = $urandom;
            sendFrame({op, p, q});
            recvResp(5, 1'b1, got);
            check($sformatf("rand%0d_op%0h", r, op), got, model(op, p, q));
        end

        // Timeout: partial frame then silence.
        sendByte(8'h00);
        sendByte(8'h11);
        sendByte(8'h22);
        errCnt = 0; errAt = 0; sawValid = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            if (err) begin
                errCnt++;
                if (errAt == 0) errAt = i;
            end
            if (bus.out_valid) sawValid = 1'b1;
            @(negedge clk);
        end
        check("to_err_count", errCnt, 1);
        check("to_err_cycle", errAt, 16);
        check("to_no_resp", sawValid, 0);
        check("to_busy", busy, 0);
        sendFrame(vecs[1].frame);
        recvResp(5, 1'b0, got);
        check("to_next_frame", got, vecs[1].resp);

        // Reset in the middle of a response.
        sendFrame(vecs[0].frame);
        recvResp(2, 1'b0, got);
        check("mid_first_bytes", got[15:0], 16'h0002);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_data", bus.out_data, 0);
        check("mid_rst_ready", bus.in_ready, 0);
        check("mid_rst_busy", busy, 0);
        sawValid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) sawValid = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (bus.out_valid) sawValid = 1'b1;
        bus.out_ready = 1'b0;
        check("mid_no_resp", sawValid, 0);
        check("mid_ready_back", bus.in_ready, 1);
        sendFrame(vecs[5].frame);
        recvResp(5, 1'b0, got);
        check("mid_next_frame", got, vecs[5].resp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
